// File: rtl/tg68k_fpu_pkg.sv
// Shared FPU definitions: extended-format struct, precision/mode encodings
// and the FMOVECR constant ROM contents.
package tg68k_fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [14:0] exp;
    logic [63:0] mant;
  } ext_t;

  localparam logic [1:0] PREC_EXT = 2'b00;
  localparam logic [1:0] PREC_SGL = 2'b01;
  localparam logic [1:0] PREC_DBL = 2'b10;

  localparam logic [1:0] RND_RN = 2'b00;
  localparam logic [1:0] RND_RZ = 2'b01;
  localparam logic [1:0] RND_RM = 2'b10;
  localparam logic [1:0] RND_RP = 2'b11;

  // Constant ROM, extended format {sign, exp, mant}
  localparam logic [79:0] CONST_PI       = 80'h4000_C90FDAA22168C235; // 0x00
  localparam logic [79:0] CONST_LOG10_2  = 80'h3FFD_9A209A84FBCFF798; // 0x0B
  localparam logic [79:0] CONST_E        = 80'h4000_ADF85458A2BB4A9A; // 0x0C
  localparam logic [79:0] CONST_LOG2_E   = 80'h3FFF_B8AA3B295C17F0BC; // 0x0D
  localparam logic [79:0] CONST_LOG10_E  = 80'h3FFD_DE5BD8A937287195; // 0x0E
  localparam logic [79:0] CONST_ZERO     = 80'h0000_0000000000000000; // 0x0F
  localparam logic [79:0] CONST_LN2      = 80'h3FFE_B17217F7D1CF79AC; // 0x30
  localparam logic [79:0] CONST_LN10     = 80'h4000_935D8DDDAAA8AC17; // 0x31
  localparam logic [79:0] CONST_1E0      = 80'h3FFF_8000000000000000; // 0x32
  localparam logic [79:0] CONST_1E1      = 80'h4002_A000000000000000; // 0x33
  localparam logic [79:0] CONST_1E2      = 80'h4005_C800000000000000; // 0x34
  localparam logic [79:0] CONST_1E4      = 80'h400C_9C40000000000000; // 0x35
  localparam logic [79:0] CONST_1E8      = 80'h4019_BEBC200000000000; // 0x36
  localparam logic [79:0] CONST_1E16     = 80'h4034_8E1BC9BF04000000; // 0x37
  localparam logic [79:0] CONST_1E32     = 80'h4069_9DC5ADA82B70B59E; // 0x38
  localparam logic [79:0] CONST_1E64     = 80'h40D3_C2781F49FFCFA6D5; // 0x39
  localparam logic [79:0] CONST_1E128    = 80'h41A8_93BA47C980E98CE0; // 0x3A
  localparam logic [79:0] CONST_1E256    = 80'h4351_AA7EEBFB9DF9DE8E; // 0x3B
  localparam logic [79:0] CONST_1E512    = 80'h46A3_E319A0AEA60E91C7; // 0x3C
  localparam logic [79:0] CONST_1E1024   = 80'h4D48_C976758681750C17; // 0x3D
  localparam logic [79:0] CONST_1E2048   = 80'h5A92_9E8B3B5DC53D5DE5; // 0x3E
  localparam logic [79:0] CONST_1E4096   = 80'h7525_C46052028A20979B; // 0x3F

  // True when the offset addresses a populated ROM entry
  function automatic logic const_hit(input logic [6:0] off);
    return (off == 7'h00) ||
           ((off >= 7'h0B) && (off <= 7'h0F)) ||
           ((off >= 7'h30) && (off <= 7'h3F));
  endfunction

  // ROM contents; unpopulated offsets read as +0
  function automatic ext_t const_value(input logic [6:0] off);
    logic [79:0] v;
    case (off)
      7'h00:   v = CONST_PI;
      7'h0B:   v = CONST_LOG10_2;
      7'h0C:   v = CONST_E;
      7'h0D:   v = CONST_LOG2_E;
      7'h0E:   v = CONST_LOG10_E;
      7'h0F:   v = CONST_ZERO;
      7'h30:   v = CONST_LN2;
      7'h31:   v = CONST_LN10;
      7'h32:   v = CONST_1E0;
      7'h33:   v = CONST_1E1;
      7'h34:   v = CONST_1E2;
      7'h35:   v = CONST_1E4;
      7'h36:   v = CONST_1E8;
      7'h37:   v = CONST_1E16;
      7'h38:   v = CONST_1E32;
      7'h39:   v = CONST_1E64;
      7'h3A:   v = CONST_1E128;
      7'h3B:   v = CONST_1E256;
      7'h3C:   v = CONST_1E512;
      7'h3D:   v = CONST_1E1024;
      7'h3E:   v = CONST_1E2048;
      7'h3F:   v = CONST_1E4096;
      default: v = 80'd0;
    endcase
    return ext_t'(v);
  endfunction

endpackage

// File: rtl/tg68k_fpu_round_ext.sv
// Combinational rounding of an extended value to single, double or
// extended mantissa width under one of the four IEEE rounding modes.
module tg68k_fpu_round_ext
  import tg68k_fpu_pkg::*;
(
  input  logic [79:0] din,
  input  logic [1:0]  prec,
  input  logic [1:0]  mode,
  output logic [79:0] dout,
  output logic        inexact
);

  ext_t        src;
  ext_t        res;
  logic [63:0] keep_mask;
  logic [63:0] guard_mask;
  logic [63:0] lsb_mask;
  logic        guard;
  logic        sticky;
  logic        lsb;
  logic        up;
  logic        is_zero;
  logic [64:0] sum;

  assign src = ext_t'(din);

  // Split mantissa into kept field / guard / sticky, decide and apply increment
  always_comb begin
    keep_mask  = '1;
    guard_mask = '0;
    lsb_mask   = 64'd1;
    case (prec)
      PREC_SGL: begin
        keep_mask  = 64'hFFFF_FF00_0000_0000;
        guard_mask = 64'h0000_0080_0000_0000;
        lsb_mask   = 64'h0000_0100_0000_0000;
      end
      PREC_DBL: begin
        keep_mask  = 64'hFFFF_FFFF_FFFF_F800;
        guard_mask = 64'h0000_0000_0000_0400;
        lsb_mask   = 64'h0000_0000_0000_0800;
      end
      default: ; // extended (and 11): nothing discarded
    endcase

    guard   = |(src.mant & guard_mask);
    sticky  = |(src.mant & ~keep_mask & ~guard_mask);
    lsb     = |(src.mant & lsb_mask);
    is_zero = (src.exp == 15'd0) && (src.mant == 64'd0);

    case (mode)
      RND_RN:  up = guard & (sticky | lsb);
      RND_RZ:  up = 1'b0;
      RND_RM:  up = src.sign & (guard | sticky);
      default: up = ~src.sign & (guard | sticky);
    endcase
    if (is_zero) up = 1'b0;

    sum = {1'b0, src.mant & keep_mask} + {1'b0, lsb_mask & {64{up}}};

    res = src;
    if (sum[64]) begin
      // kept field overflowed: renormalise to 1.000... with exponent bump
      res.mant = 64'h8000_0000_0000_0000;
      res.exp  = src.exp + 15'd1;
    end else begin
      res.mant = sum[63:0];
    end

    dout    = res;
    inexact = guard | sticky;
  end

endmodule

// File: rtl/tg68k_fpu_const_rom_rnd.sv
// Pipelined FMOVECR constant source: S1 looks up the ROM, S2 rounds to the
// requested precision. Two-stage elastic pipe with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; a producer holds valid and its payload until that edge, and ready may
// depend combinationally on the downstream ready but never on valid.
module tg68k_fpu_const_rom_rnd
  import tg68k_fpu_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_offset,
  input  logic [1:0]       req_prec,
  input  logic [1:0]       req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [79:0]      rsp_data,
  output logic             rsp_inexact,
  output logic             rsp_unsupp,
  output logic [TAG_W-1:0] rsp_tag
);

  // S1: lookup result
  logic             s1_valid;
  logic [79:0]      s1_val;
  logic             s1_unsupp;
  logic [1:0]       s1_prec;
  logic [1:0]       s1_mode;
  logic [TAG_W-1:0] s1_tag;

  // S2: rounded response
  logic             s2_valid;
  logic [79:0]      s2_data;
  logic             s2_inexact;
  logic             s2_unsupp;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_load;
  logic [79:0]      rnd_val;
  logic             rnd_inexact;

  // S2 can take new content when empty or when its response leaves this cycle
  assign s2_load   = !s2_valid || rsp_ready;
  assign req_ready = !s1_valid || s2_load;

  assign rsp_valid   = s2_valid;
  assign rsp_data    = s2_data;
  assign rsp_inexact = s2_inexact;
  assign rsp_unsupp  = s2_unsupp;
  assign rsp_tag     = s2_tag;

  generate
    if (ROUND_EN) begin : g_round
      tg68k_fpu_round_ext u_round (
        .din     (s1_val),
        .prec    (s1_prec),
        .mode    (s1_mode),
        .dout    (rnd_val),
        .inexact (rnd_inexact)
      );
    end else begin : g_pass
      assign rnd_val     = s1_val;
      assign rnd_inexact = 1'b0;
    end
  endgenerate

  // S1 register: capture ROM value and request attributes on handshake
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_valid  <= 1'b0;
      s1_val    <= '0;
      s1_unsupp <= 1'b0;
      s1_prec   <= PREC_EXT;
      s1_mode   <= RND_RN;
      s1_tag    <= '0;
    end else if (req_ready) begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_val    <= const_value(req_offset);
        s1_unsupp <= !const_hit(req_offset);
        s1_prec   <= req_prec;
        s1_mode   <= req_mode;
        s1_tag    <= req_tag;
      end
    end
  end

  // S2 register: capture rounded value; holds while stalled by rsp_ready
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_inexact <= 1'b0;
      s2_unsupp  <= 1'b0;
      s2_tag     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data    <= rnd_val;
        s2_inexact <= rnd_inexact;
        s2_unsupp  <= s1_unsupp;
        s2_tag     <= s1_tag;
      end
    end
  end

endmodule
